rsc_frame_encoder: RTL and testbench

Frame-level controller that sequences the 4-state recursive systematic convolutional encoder (feedback 7, generators 5 and 7) used by the turbo encoder. It accepts a frame of information bits over a valid/ready stream, runs them through the encoder, and appends two trellis-termination steps that drive the encoder back to state 0. It presents one 2-bit code symbol per step on a registered, back-pressurable output stream. It sits between the frame buffer/interleaver and the puncturing/output stage.

---
 rtl/rsc_frame_encoder.sv | 116 +++++++++++
 tb/tb_rsc_frame_encoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rsc_frame_encoder.sv
// Frame controller for the 4-state RSC encoder (feedback 7, generators 5/7).
// Streams data symbols, then two termination steps that return the encoder to state 0.
module rsc_frame_encoder #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    output logic             busy,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_bits,
    output logic             out_tail,
    output logic             out_last,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        TAIL1,
        TAIL2,
        DRAIN
    } state_t;

    state_t           state;
    logic             s1;
    logic             s0;
    logic [LEN_W-1:0] cnt;

    logic slot_free;
    logic load;
    logic u;
    logic a;
    logic par;

    assign slot_free = !out_valid || out_ready;
    assign busy      = (state != IDLE);
    assign in_ready  = (state == DATA) && slot_free;

    // Tail steps feed back s1^s0 so the recursion term a collapses to 0.
    always_comb begin
        u    = (state == DATA) ? in_bit : (s1 ^ s0);
        a    = u ^ s1 ^ s0;
        par  = a ^ s0;
        load = 1'b0;
        if (state == DATA)
            load = in_valid && slot_free;
        else if (state == TAIL1 || state == TAIL2)
            load = slot_free;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            s1        <= 1'b0;
            s0        <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_bits  <= 2'b00;
            out_tail  <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (load) begin
                out_valid <= 1'b1;
                out_bits  <= {u, par};
                out_tail  <= (state != DATA);
                out_last  <= (state == TAIL2);
                s1        <= a;
                s0        <= s1;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (frame_len == '0) begin
                            err <= 1'b1;
                        end else begin
                            state <= DATA;
                            cnt   <= frame_len;
                            s1    <= 1'b0;
                            s0    <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (load) begin
                        cnt <= cnt - 1'b1;
                        if (cnt == LEN_W'(1))
                            state <= TAIL1;
                    end
                end
                TAIL1: if (load) state <= TAIL2;
                TAIL2: if (load) state <= DRAIN;
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsc_frame_encoder.sv
// Self-checking bench for rsc_frame_encoder: directed scenarios plus
// randomized frames/stalls compared against a recursion-sequence model.
module tb_rsc_frame_encoder;

    typedef bit         bit_q_t[$];
    typedef logic [3:0] sym_q_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] frame_len;
    logic        busy;
    logic        in_valid;
    logic        in_bit;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_bits;
    logic        out_tail;
    logic        out_last;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;

    logic [3:0] got[$];
    logic       held = 1'b0;
    logic [3:0] hsym;

    rsc_frame_encoder #(.LEN_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .frame_len(frame_len),
        .busy(busy), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_bits(out_bits), .out_tail(out_tail), .out_last(out_last),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a[k] = u[k]^a[k-1]^a[k-2], parity = a[k]^a[k-2].
    // Symbol packing is {tail, last, systematic, parity}.
    function automatic sym_q_t model(input bit_q_t b);
        sym_q_t q;
        bit     av[$];
        bit     uu;
        bit     ak;
        int     m;
        av = '{1'b0, 1'b0};
        for (int k = 0; k < b.size(); k++) begin
            m  = av.size();
            uu = b[k];
            ak = uu ^ av[m-1] ^ av[m-2];
            q.push_back({2'b00, uu, ak ^ av[m-2]});
            av.push_back(ak);
        end
        for (int t = 0; t < 2; t++) begin
            m  = av.size();
            uu = av[m-1] ^ av[m-2];
            q.push_back({1'b1, t == 1, uu, av[m-2]});
            av.push_back(1'b0);
        end
        return q;
    endfunction

    // Output monitor: records accepted beats, checks stall stability.
    always @(negedge clk) begin
        if (reset) begin
            held = 1'b0;
        end else begin
            if (held)
                chk("stall_hold", {out_valid, out_tail, out_last, out_bits},
                    {1'b1, hsym});
            held = out_valid && !out_ready;
            hsym = {out_tail, out_last, out_bits};
            if (out_valid && out_ready)
                got.push_back({out_tail, out_last, out_bits});
            if (err)
                err_cnt++;
        end
    end

    // Entered and left at posedge+1.
    task automatic run_frame(input bit_q_t bits, input bit stall,
                             input bit started, input int next_len);
        sym_q_t exp;
        int     n;
        int     idx;
        int     cyc;
        bit     acc;
        bit     fin;
        n   = bits.size();
        exp = model(bits);
        idx = 0;
        cyc = 0;
        fin = 1'b0;
        if (!started) begin
            start     = 1'b1;
            frame_len = 16'(n);
        end
        @(posedge clk); #1;
        start = 1'b0;
        got.delete();
        chk("busy_after_start", busy, 1);
        chk("in_ready_after_start", in_ready, 1);
        while (!fin && cyc < 2000) begin
            in_valid  = (idx < n) && (!stall || $urandom_range(0, 2) != 0);
            in_bit    = (idx < n) ? bits[idx] : 1'b0;
            out_ready = !stall || ($urandom_range(0, 1) == 1);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc)
                idx++;
            fin = done;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("done_seen", fin, 1);
        chk("bits_used", idx, n);
        if (!stall)
            chk("frame_cycles", cyc, n + 3);
        chk("beats", got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk($sformatf("sym%0d", i), got[i], exp[i]);
        if (next_len > 0) begin
            chk("busy_in_done_cycle", busy, 0);
            start     = 1'b1;
            frame_len = 16'(next_len);
        end else begin
            @(posedge clk); #1;
            chk("done_pulse_width", done, 0);
        end
    endtask

    initial begin
        bit_q_t f10;
        bit_q_t f1;
        bit_q_t f3;
        bit_q_t fr;
        f10 = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
        f1  = '{1};
        f3  = '{0, 1, 1};

        reset     = 1'b1;
        start     = 1'b0;
        frame_len = '0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outs", {out_bits, out_tail, out_last, done, err}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_frame(f10, 1'b0, 1'b0, 0);
        run_frame(f1, 1'b0, 1'b0, 0);
        run_frame(f10, 1'b1, 1'b0, 0);

        start     = 1'b1;
        frame_len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        @(posedge clk); #1;
        chk("err_one_cycle", err, 0);
        chk("err_no_output", out_valid, 0);
        run_frame(f3, 1'b0, 1'b0, 0);

        start     = 1'b1;
        frame_len = 16'd10;
        @(posedge clk); #1;
        start     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_bit = f10[i];
            @(posedge clk); #1;
        end
        chk("pre_reset_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("reset_async_valid", out_valid, 0);
        chk("reset_async_busy", busy, 0);
        chk("reset_async_ready", in_ready, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        run_frame(f10, 1'b0, 1'b0, 0);

        run_frame(f10, 1'b0, 1'b0, 3);
        run_frame(f3, 1'b0, 1'b1, 0);

        for (int r = 0; r < 5; r++) begin
            fr.delete();
            for (int k = 0; k < $urandom_range(1, 24); k++)
                fr.push_back(1'($urandom_range(0, 1)));
            run_frame(fr, 1'(r % 2), 1'b0, 0);
        end

        chk("err_count", err_cnt, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
